// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU through an IDLE/EXEC/DONE FSM.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed priority (requester 0 wins).
module alu_arbiter #(
  parameter logic [5:0] NOOP_OP = 6'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_vld,
  input  logic [5:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_gnt,
  output logic        req0_done,
  output logic [31:0] req0_res,
  output logic [2:0]  req0_nzv,
  input  logic        req1_vld,
  input  logic [5:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_gnt,
  output logic        req1_done,
  output logic [31:0] req1_res,
  output logic [2:0]  req1_nzv,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_ADDI = 6'h21;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_NAND = 6'h23;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_ANDI = 6'h25;
  localparam logic [5:0] OP_SRL  = 6'h26;
  localparam logic [5:0] OP_SLL  = 6'h27;
  localparam logic [5:0] OP_XOR  = 6'h28;

  logic [1:0]  state;
  logic        owner;
  logic [5:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        any_vld;
  logic        grant;
  logic        win;

  logic [31:0] alu_res;
  logic        alu_v;
  logic        flag_upd;
  logic [32:0] sum33;
  logic [31:0] diff;
  logic        big_shift;

  assign any_vld = req0_vld | req1_vld;
  assign grant   = (state == IDLE) && any_vld && !rst;

`ifdef ALU_ARB_RR_EN
  // prio1 set means requester 1 wins the next tie; it flips to the loser on every grant.
  logic prio1;
  assign win = req1_vld && (!req0_vld || prio1);

  always_ff @(posedge clk) begin
    if (rst)        prio1 <= 1'b0;
    else if (grant) prio1 <= ~win;
  end
`else
  assign win = req1_vld && !req0_vld;
`endif

  assign req0_gnt  = grant && !win;
  assign req1_gnt  = grant && win;
  assign req0_done = (state == DONE) && !owner && !rst;
  assign req1_done = (state == DONE) && owner && !rst;
  assign busy      = (state != IDLE);

  assign sum33     = {1'b0, a_q} + {1'b0, b_q};
  assign diff      = a_q - b_q;
  assign big_shift = |b_q[31:5];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res  = 32'd0;
    alu_v    = 1'b0;
    flag_upd = 1'b0;
    if (op_q != NOOP_OP) begin
      case (op_q)
        OP_ADD: begin
          alu_res  = sum33[31:0];
          alu_v    = (a_q[31] == b_q[31]) && (sum33[31] != a_q[31]);
          flag_upd = 1'b1;
        end
        OP_ADDI: begin
          alu_res  = sum33[31:0];
          alu_v    = sum33[32];
          flag_upd = 1'b1;
        end
        OP_SUB: begin
          alu_res  = diff;
          alu_v    = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
          flag_upd = 1'b1;
        end
        OP_NAND: begin
          alu_res  = ~(a_q & b_q);
          flag_upd = 1'b1;
        end
        OP_AND, OP_ANDI: begin
          alu_res  = a_q & b_q;
          flag_upd = 1'b1;
        end
        OP_XOR: begin
          alu_res  = a_q ^ b_q;
          flag_upd = 1'b1;
        end
        OP_SRL:  alu_res = big_shift ? 32'd0 : (a_q >> b_q[4:0]);
        OP_SLL:  alu_res = big_shift ? 32'd0 : (a_q << b_q[4:0]);
        default: alu_res = 32'd0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      op_q     <= 6'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      req0_res <= 32'd0;
      req0_nzv <= 3'b000;
      req1_res <= 32'd0;
      req1_nzv <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (any_vld) begin
            owner <= win;
            op_q  <= win ? req1_op : req0_op;
            a_q   <= win ? req1_a  : req0_a;
            b_q   <= win ? req1_b  : req0_b;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (owner) begin
            req1_res <= alu_res;
            if (flag_upd) req1_nzv <= {alu_res[31], alu_res == 32'd0, alu_v};
          end else begin
            req0_res <= alu_res;
            if (flag_upd) req0_nzv <= {alu_res[31], alu_res == 32'd0, alu_v};
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; expectations follow the build's ALU_ARB_RR_EN setting.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_vld, req1_vld;
  logic [5:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_gnt, req1_gnt, req0_done, req1_done, busy;
  logic [31:0] req0_res, req1_res;
  logic [2:0]  req0_nzv, req1_nzv;

  int errors = 0;
  int checks = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_gnt(req0_gnt), .req0_done(req0_done), .req0_res(req0_res), .req0_nzv(req0_nzv),
    .req1_vld(req1_vld), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_gnt(req1_gnt), .req1_done(req1_done), .req1_res(req1_res), .req1_nzv(req1_nzv),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic who, input logic vld, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (who) begin
      req1_vld = vld; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_vld = vld; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // One full transaction from an idle arbiter, checking gnt, busy and done timing.
  task automatic do_op(input string tag, input logic who, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(who, 1'b1, op, a, b);
    #1;
    check({tag, " gnt"},   32'(who ? req1_gnt : req0_gnt), 32'd1);
    check({tag, " gnt_o"}, 32'(who ? req0_gnt : req1_gnt), 32'd0);
    @(negedge clk);
    drive(who, 1'b0, 6'd0, 32'd0, 32'd0);
    #1;
    check({tag, " busy"},  32'(busy), 32'd1);
    check({tag, " early"}, 32'(who ? req1_done : req0_done), 32'd0);
    @(negedge clk);
    #1;
    check({tag, " done"},   32'(who ? req1_done : req0_done), 32'd1);
    check({tag, " done_o"}, 32'(who ? req0_done : req1_done), 32'd0);
    @(negedge clk);
    #1;
    check({tag, " done1x"}, 32'(req0_done | req1_done), 32'd0);
    check({tag, " idle"},   32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 6'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);

    // Reset state, and reset overriding a pending request.
    @(negedge clk);
    drive(1'b0, 1'b1, 6'h20, 32'd1, 32'd1);
    #1;
    check("rst gnt0", 32'(req0_gnt), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst res0", req0_res, 32'd0);
    check("rst res1", req1_res, 32'd0);
    check("rst nzv0", 32'(req0_nzv), 32'd0);
    check("rst nzv1", 32'(req1_nzv), 32'd0);
    @(negedge clk);
    #1;
    check("rst busy2", 32'(busy), 32'd0);
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    rst = 1'b0;

    // Signed overflow on ADD.
    do_op("add0", 1'b0, 6'h20, 32'h7FFF_FFFF, 32'd1);
    check("add0 res", req0_res, 32'h8000_0000);
    check("add0 nzv", 32'(req0_nzv), 32'd5);
    check("add0 res1", req1_res, 32'd0);

    // SUB to zero, then a shift leaves the flags alone.
    do_op("sub1", 1'b1, 6'h22, 32'd5, 32'd5);
    check("sub1 res", req1_res, 32'd0);
    check("sub1 nzv", 32'(req1_nzv), 32'd2);
    do_op("sll1", 1'b1, 6'h27, 32'd1, 32'd4);
    check("sll1 res", req1_res, 32'h10);
    check("sll1 nzv", 32'(req1_nzv), 32'd2);

    do_op("and1", 1'b1, 6'h24, 32'h8000_0000, 32'hFFFF_FFFF);
    check("and1 res", req1_res, 32'h8000_0000);
    check("and1 nzv", 32'(req1_nzv), 32'd4);

    // Flags are private per requester.
    do_op("xor0", 1'b0, 6'h28, 32'hF0F0_F0F0, 32'hF0F0_F0F0);
    check("xor0 res", req0_res, 32'd0);
    check("xor0 nzv", 32'(req0_nzv), 32'd2);
    check("xor0 nzv1", 32'(req1_nzv), 32'd4);
    check("xor0 res1", req1_res, 32'h8000_0000);

    do_op("nand1", 1'b1, 6'h23, 32'd0, 32'd0);
    check("nand1 res", req1_res, 32'hFFFF_FFFF);
    check("nand1 nzv", 32'(req1_nzv), 32'd4);
    do_op("sllbig1", 1'b1, 6'h27, 32'd1, 32'd32);
    check("sllbig1 res", req1_res, 32'd0);
    check("sllbig1 nzv", 32'(req1_nzv), 32'd4);
    do_op("srl1", 1'b1, 6'h26, 32'h8000_0000, 32'd31);
    check("srl1 res", req1_res, 32'd1);
    check("srl1 nzv", 32'(req1_nzv), 32'd4);

    // ADDI: V is carry out, not signed overflow.
    do_op("addi0", 1'b0, 6'h21, 32'hFFFF_FFFF, 32'd2);
    check("addi0 res", req0_res, 32'd1);
    check("addi0 nzv", 32'(req0_nzv), 32'd1);
    do_op("undef0", 1'b0, 6'h01, 32'd7, 32'd9);
    check("undef0 res", req0_res, 32'd0);
    check("undef0 nzv", 32'(req0_nzv), 32'd1);
    do_op("subov0", 1'b0, 6'h22, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    check("subov0 res", req0_res, 32'h8000_0000);
    check("subov0 nzv", 32'(req0_nzv), 32'd5);
    do_op("noop0", 1'b0, 6'h3F, 32'd3, 32'd4);
    check("noop0 res", req0_res, 32'd0);
    check("noop0 nzv", 32'(req0_nzv), 32'd5);

    // Reset during EXEC aborts the operation.
    @(negedge clk);
    drive(1'b1, 1'b1, 6'h21, 32'hFFFF_FFFF, 32'd2);
    #1;
    check("abort gnt1", 32'(req1_gnt), 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 6'd0, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd1);
    check("abort done", 32'(req1_done), 32'd0);
    @(negedge clk);
    #1;
    check("abort busy0", 32'(busy), 32'd0);
    check("abort done1", 32'(req1_done), 32'd0);
    check("abort res1", req1_res, 32'd0);
    check("abort nzv1", 32'(req1_nzv), 32'd0);
    rst = 1'b0;
    do_op("post1", 1'b1, 6'h20, 32'd2, 32'd3);
    check("post1 res", req1_res, 32'd5);
    check("post1 nzv", 32'(req1_nzv), 32'd0);

    // Both requesters valid continuously; vld held past done is a new request.
    @(negedge clk);
    drive(1'b0, 1'b1, 6'h20, 32'd1, 32'd1);
    drive(1'b1, 1'b1, 6'h20, 32'd2, 32'd2);
    #1;
    for (int c = 0; c < 12; c++) begin
`ifdef ALU_ARB_RR_EN
      check($sformatf("arb gnt0 c%0d", c), 32'(req0_gnt), 32'((c % 3 == 0) && ((c / 3) % 2 == 0)));
      check($sformatf("arb gnt1 c%0d", c), 32'(req1_gnt), 32'((c % 3 == 0) && ((c / 3) % 2 == 1)));
`else
      check($sformatf("arb gnt0 c%0d", c), 32'(req0_gnt), 32'(c % 3 == 0));
      check($sformatf("arb gnt1 c%0d", c), 32'(req1_gnt), 32'd0);
`endif
      @(negedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 6'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("arb res0", req0_res, 32'd2);
`ifdef ALU_ARB_RR_EN
    check("arb res1", req1_res, 32'd4);
`else
    check("arb res1", req1_res, 32'd5);
`endif
    check("arb idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NOOP_OP, default 6'h3F, opcode treated as no-op.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqX_vld  input  1  (X = 0,1) requester X has an operation pending.
REQ-005 reqX_op  input  6  opcode; codes: ADD 20h, ADDI 21h, SUB 22h, NAND 23h, AND 24h, ANDI 25h, SRL 26h, SLL 27h, XOR 28h, NO_OP 3Fh.
REQ-006 reqX_a, reqX_b  input  32  operand 1 (shift value) and operand 2 (shift amount).
REQ-007 reqX_gnt  output  1  request accepted this cycle.
REQ-008 reqX_done  output  1  one-cycle pulse, result valid.
REQ-009 reqX_res  output  32  result for requester X.
REQ-010 reqX_nzv  output  3  flags {N,Z,V} private to requester X.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL share one combinational ALU between two requesters using FSM states IDLE, EXEC, DONE.
REQ-013 IDLE: if any reqX_vld, the block SHALL assert the winner's reqX_gnt combinationally that cycle, latch its op/a/b and owner ID at the edge, and move to EXEC; otherwise stay IDLE.
REQ-014 EXEC: the ALU SHALL evaluate the latched operands; result and flags SHALL be registered at the edge; next state DONE.
REQ-015 DONE: reqX_done SHALL be high for exactly one cycle for the owner only; next state IDLE.
REQ-016 Latency: done SHALL assert two cycles after the gnt cycle; throughput one operation per three cycles.
REQ-017 reqX_vld asserted while in EXEC or DONE SHALL be ignored (no gnt) until IDLE; requester SHALL hold vld and operands stable until gnt.
REQ-018 A vld still high in the cycle after done SHALL be treated as a new request.
REQ-019 ADD/SUB: 32-bit wrap-around result; V = signed two's-complement overflow.
REQ-020 ADDI: 32-bit wrap-around result; V = carry out of bit 31.
REQ-021 AND, ANDI, NAND, XOR: bitwise result, V = 0.
REQ-022 For REQ-019..021 ops: N = res[31], Z = (res == 0); owner's nzv SHALL update at the EXEC edge.
REQ-023 SLL/SRL: logical shift of a by b (b >= 32 gives 0); owner's nzv SHALL be unchanged.
REQ-024 NOOP_OP and undefined opcodes: res = 0, nzv unchanged, done still pulses.
REQ-025 reqX_res and reqX_nzv SHALL hold their value until X's next completed operation; the other requester's operations SHALL never modify them.
REQ-026 Arbitration when both valid in IDLE: per Configuration.

Reset
REQ-027 On rst: state IDLE, gnt/done/busy 0, res0/res1 0, nzv0/nzv1 3'b000, round-robin pointer favours requester 0.
REQ-028 rst asserted in EXEC or DONE SHALL abort the operation with no done pulse and no flag update.
REQ-029 rst SHALL take priority over any simultaneous request.

Configuration
REQ-030 Macro ALU_ARB_RR_EN defined: round-robin; when both valid, grant the requester not granted last; a single valid requester is always granted.
REQ-031 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; pointer logic absent.

Verification
REQ-032 Req0 ADD a=7FFF_FFFF b=1 -> gnt0 cycle T, done0 at T+2, res0=8000_0000, nzv0=3'b101.
REQ-033 Req1 SUB a=5 b=5, then SLL a=1 b=4 -> res1=0, nzv1=3'b010; then res1=10h, nzv1 still 3'b010.
REQ-034 Both valid continuously (RR_EN) -> grants alternate 0,1,0,1; without macro -> req0 granted every time, req1 never.
REQ-035 Req0 XOR a=F0F0_F0F0 b=F0F0_F0F0 while req1 nzv=3'b100 -> nzv0=3'b010, nzv1 unchanged 3'b100.
REQ-036 rst pulsed during EXEC of req1 ADDI -> no done1, busy 0 next cycle, res1=0, nzv1=0; subsequent req1 request granted normally.
